// File: rtl/fifo_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_prefetch_pkg
// Purpose  : Shared constants and buffer-index helpers for the prefetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_prefetch_pkg;

    localparam int MAX_READ_LATENCY = 2;
    localparam int MAX_BUF_DEPTH    = MAX_READ_LATENCY + 2;
    localparam int BUF_IDX_W        = $clog2(MAX_BUF_DEPTH);

    // Wide enough for the deepest legal buffer; shallower buffers wrap early.
    typedef logic [BUF_IDX_W-1:0] buf_idx_t;

    function automatic buf_idx_t buf_idx_next(input buf_idx_t idx, input int depth);
        if (int'(idx) == depth - 1) begin
            return '0;
        end
        return idx + buf_idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_skid_buf
// Purpose  : Flop-array circular buffer with head/tail pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_skid_buf
    import fifo_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    buf_idx_t              r_head;
    buf_idx_t              r_tail;
    logic [CNT_W-1:0]      r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_en) begin
                r_tail <= buf_idx_next(r_tail, DEPTH);
            end
            if (i_rd_en) begin
                r_head <= buf_idx_next(r_head, DEPTH);
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is reset too so the head entry reads as zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && !i_clear) begin
            r_mem[r_tail] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_head];
    assign o_count   = r_count;

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        (i_wr_en && !i_clear) |-> (r_count != CNT_W'(DEPTH)));

    a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
        (i_rd_en && !i_clear) |-> (r_count != '0));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        r_count <= CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fifo_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_prefetch_stage
// Purpose  : Prefetches from a fixed-latency BRAM FIFO into a small skid buffer
//            so the consumer sees registered valid/data at full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_prefetch_stage
    import fifo_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH   = 36,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]             fifo_data_i,
    output logic                              fifo_pop_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic [$clog2(READ_LATENCY+3)-1:0] count_o
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
            $error("fifo_prefetch_stage: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [READ_LATENCY-1:0] r_ret_vld;
    logic [CNT_W-1:0]        w_buf_cnt;
    logic [CNT_W-1:0]        w_inflight;
    logic [CNT_W:0]          w_occupancy;
    logic                    w_pop;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_valid;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            w_inflight = w_inflight + CNT_W'(r_ret_vld[k]);
        end
    end

    // Credit covers words already buffered plus those still in the BRAM pipe;
    // the consumer handshake is deliberately left out of this path.
    assign w_occupancy = {1'b0, w_buf_cnt} + {1'b0, w_inflight};
    assign w_pop       = !fifo_empty_i && !flush_i && !rst_i
                         && (w_occupancy < (CNT_W + 1)'(BUF_DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ret_vld <= '0;
        end else if (flush_i) begin
            r_ret_vld <= '0;
        end else begin
            r_ret_vld[0] <= w_pop;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_ret_vld[k] <= r_ret_vld[k-1];
            end
        end
    end

    assign w_wr_en = r_ret_vld[READ_LATENCY-1] && !flush_i;
    assign w_valid = (w_buf_cnt != '0);
    assign w_rd_en = w_valid && ready_i;

    prefetch_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .CNT_W      (CNT_W)
    ) u_skid_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_clear   (flush_i),
        .i_wr_en   (w_wr_en),
        .i_wr_data (fifo_data_i),
        .i_rd_en   (w_rd_en),
        .o_rd_data (data_o),
        .o_count   (w_buf_cnt)
    );

    assign fifo_pop_o = w_pop;
    assign valid_o    = w_valid;
    assign count_o    = w_buf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_prefetch_stage
// Purpose  : Directed and random checks of fifo_prefetch_stage at latency 1 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_prefetch_stage;

    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic ready;
    logic hold_empty;
    int   src_end [2] = '{0, 0};

    int n_tests = 0;
    int n_fail  = 0;

    int fw0, fw1, first0, first1, nv0, nv1, last0, last1;
    bit got0, got1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT   = g + 1;
        localparam int DEPTH = LAT + 2;
        localparam int CW    = $clog2(DEPTH + 1);

        logic          pop, valid, empty;
        logic [DW-1:0] fdata, dout;
        logic [CW-1:0] cnt;
        logic [DW-1:0] pipe [2];
        logic [DW-1:0] exp_q [$];
        int            src_next = 1;
        int            n_xfer   = 0;

        assign empty = hold_empty || (src_next >= src_end[g]);
        assign fdata = pipe[LAT-1];

        fifo_prefetch_stage #(
            .DATA_WIDTH   (DW),
            .READ_LATENCY (LAT)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .flush_i      (flush),
            .fifo_empty_i (empty),
            .fifo_data_i  (fdata),
            .fifo_pop_o   (pop),
            .valid_o      (valid),
            .ready_i      (ready),
            .data_o       (dout),
            .count_o      (cnt)
        );

        // Upstream BRAM FIFO: word values are sequence numbers, garbage otherwise.
        always @(posedge clk) begin
            if (pop) begin
                pipe[0]  <= DW'(src_next);
                src_next <= src_next + 1;
            end else begin
                pipe[0] <= {4'hF, 32'($urandom)};
            end
            pipe[1] <= pipe[0];
        end

        always @(negedge clk) begin
            chk("cnt_bound", 64'(cnt <= CW'(DEPTH)), 1);
            if (valid) begin
                chk("sb_has_data", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("data_order", dout, exp_q[0]);
                    if (ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            if (flush || rst) begin
                exp_q.delete();
            end
            if (pop) begin
                exp_q.push_back(DW'(src_next));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic avail(input int n);
        src_end[0] = g_dut[0].src_next + n;
        src_end[1] = g_dut[1].src_next + n;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ready = 1'b0; hold_empty = 1'b0;
        #1 rst = 1'b1;
        avail(5);
        repeat (3) @(negedge clk);
        chk("rst_pop_l1",   g_dut[0].pop,   0);
        chk("rst_valid_l1", g_dut[0].valid, 0);
        chk("rst_data_l1",  g_dut[0].dout,  0);
        chk("rst_cnt_l1",   g_dut[0].cnt,   0);
        chk("rst_pop_l2",   g_dut[1].pop,   0);
        chk("rst_valid_l2", g_dut[1].valid, 0);
        chk("rst_cnt_l2",   g_dut[1].cnt,   0);

        next_cycle();
        rst = 1'b0; hold_empty = 1'b1; ready = 1'b1;
        repeat (2) next_cycle();

        // Three words appear at cycle 0, consumer always ready.
        avail(3); hold_empty = 1'b0;
        @(negedge clk);
        chk("w3_c0_pop",   g_dut[0].pop,   1);
        chk("w3_c0_valid", g_dut[0].valid, 0);
        @(negedge clk);
        chk("w3_c1_pop",   g_dut[0].pop,   1);
        chk("w3_c1_valid", g_dut[0].valid, 0);
        @(negedge clk);
        chk("w3_c2_pop",   g_dut[0].pop,   1);
        chk("w3_c2_valid", g_dut[0].valid, 1);
        chk("w3_c2_data",  g_dut[0].dout,  1);
        chk("w3_c2_l2_valid", g_dut[1].valid, 0);
        @(negedge clk);
        chk("w3_c3_pop",  g_dut[0].pop,  0);
        chk("w3_c3_data", g_dut[0].dout, 2);
        chk("w3_c3_l2_data", g_dut[1].dout, 1);
        @(negedge clk);
        chk("w3_c4_data",  g_dut[0].dout,  3);
        chk("w3_c4_valid", g_dut[0].valid, 1);
        @(negedge clk);
        chk("w3_c5_valid", g_dut[0].valid, 0);

        // Backpressure with plenty of source data: buffer fills, pops stop.
        next_cycle();
        ready = 1'b0; avail(10);
        repeat (8) @(negedge clk);
        chk("bp_pop_l1",  g_dut[0].pop,  0);
        chk("bp_cnt_l1",  g_dut[0].cnt,  3);
        chk("bp_data_l1", g_dut[0].dout, 4);
        chk("bp_pop_l2",  g_dut[1].pop,  0);
        chk("bp_cnt_l2",  g_dut[1].cnt,  4);
        next_cycle();
        ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_drain_cnt_l1", g_dut[0].cnt, 0);
        chk("bp_drain_sb_l1",  g_dut[0].exp_q.size(), 0);
        chk("bp_drain_sb_l2",  g_dut[1].exp_q.size(), 0);

        // Continuous stream of 100 words.
        next_cycle();
        avail(100);
        first0 = -1; first1 = -1; nv0 = 0; nv1 = 0; last0 = 0; last1 = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (g_dut[0].valid) begin
                if (first0 < 0) first0 = c;
                nv0++; last0 = c;
            end
            if (g_dut[1].valid) begin
                if (first1 < 0) first1 = c;
                nv1++; last1 = c;
            end
        end
        chk("st_l1_first", first0, 2);
        chk("st_l1_count", nv0, 100);
        chk("st_l2_first", first1, 3);
        chk("st_l2_count", nv1, 100);
        chk("st_l2_span",  last1 - first1 + 1, 100);

        // Flush with two words buffered and one in flight (latency 1).
        next_cycle();
        ready = 1'b0; avail(4);
        repeat (3) @(negedge clk);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_cnt_before_l1", g_dut[0].cnt, 2);
        chk("fl_pop_l1", g_dut[0].pop, 0);
        chk("fl_pop_l2", g_dut[1].pop, 0);
        next_cycle();
        flush = 1'b0; ready = 1'b1;
        fw0 = g_dut[0].src_next; fw1 = g_dut[1].src_next;
        @(negedge clk);
        chk("fl_cnt_after_l1", g_dut[0].cnt, 0);
        chk("fl_cnt_after_l2", g_dut[1].cnt, 0);
        got0 = 1'b0; got1 = 1'b0;
        for (int c = 0; c < 12 && !(got0 && got1); c++) begin
            @(negedge clk);
            if (!got0 && g_dut[0].valid) begin
                chk("fl_first_l1", g_dut[0].dout, DW'(fw0));
                got0 = 1'b1;
            end
            if (!got1 && g_dut[1].valid) begin
                chk("fl_first_l2", g_dut[1].dout, DW'(fw1));
                got1 = 1'b1;
            end
        end
        chk("fl_resumed", {got0, got1}, 2'b11);

        // Asynchronous reset in the middle of a stream.
        next_cycle();
        avail(30);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_pop_l1",   g_dut[0].pop,   0);
        chk("ar_valid_l1", g_dut[0].valid, 0);
        chk("ar_data_l1",  g_dut[0].dout,  0);
        chk("ar_cnt_l1",   g_dut[0].cnt,   0);
        chk("ar_valid_l2", g_dut[1].valid, 0);
        chk("ar_data_l2",  g_dut[1].dout,  0);
        repeat (2) next_cycle();
        rst = 1'b0;
        fw0 = g_dut[0].src_next; fw1 = g_dut[1].src_next;
        got0 = 1'b0; got1 = 1'b0;
        for (int c = 0; c < 12 && !(got0 && got1); c++) begin
            @(negedge clk);
            if (!got0 && g_dut[0].valid) begin
                chk("ar_first_l1", g_dut[0].dout, DW'(fw0));
                got0 = 1'b1;
            end
            if (!got1 && g_dut[1].valid) begin
                chk("ar_first_l2", g_dut[1].dout, DW'(fw1));
                got1 = 1'b1;
            end
        end
        chk("ar_resumed", {got0, got1}, 2'b11);

        // Random ready, source gaps and occasional flushes.
        next_cycle();
        avail(100000);
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            ready      = ($urandom_range(0, 1) == 1);
            hold_empty = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 149) == 0);
        end
        next_cycle();
        flush = 1'b0; hold_empty = 1'b1; ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("rnd_cnt_l1",   g_dut[0].cnt, 0);
        chk("rnd_cnt_l2",   g_dut[1].cnt, 0);
        chk("rnd_valid_l1", g_dut[0].valid, 0);
        chk("rnd_sb_l1",    g_dut[0].exp_q.size(), 0);
        chk("rnd_sb_l2",    g_dut[1].exp_q.size(), 0);
        chk("rnd_traffic_l1", 64'(g_dut[0].n_xfer > 1000), 1);
        chk("rnd_traffic_l2", 64'(g_dut[1].n_xfer > 1000), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
